// File: rtl/fitness_pkg.sv
// Purpose : shared state encoding and derived-size helpers for the fitness evaluator.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package fitness_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of serial compare cycles for one image.
    function automatic int num_chunks(input int width, input int height, input int chunk);
        return (width * height) / chunk;
    endfunction

    // Width of the chunk counter; at least one bit even for a single chunk.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Best-score reset value for the default ScoreWidth of 9.
    localparam int                     DefScoreWidth = 9;
    localparam logic [DefScoreWidth-1:0] ScoreAllOnes = '1;

endpackage

// File: rtl/fitness_evaluator_popcount_unit.sv
// Purpose : combinational population count of one ChunkWidth-bit slice.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports   : vec_i  - slice to count
//           count_o - number of set bits, ScoreWidth wide
module popcount_unit #(
    parameter int ChunkWidth = 16,
    parameter int ScoreWidth = 9
) (
    input  logic [ChunkWidth-1:0] vec_i,
    output logic [ScoreWidth-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < ChunkWidth; i++) begin
            count_o = count_o + ScoreWidth'(vec_i[i]);
        end
    end

endmodule

// File: rtl/fitness_evaluator.sv
// Purpose : Hamming distance of processed image vs target, ChunkWidth pixels per cycle,
//           with best-score/best-id tracking across evaluations.
// Latency : start accepted at edge k -> done pulse after edge k+NumChunks+1.
// Backpressure: none; start is only honoured in IDLE, otherwise dropped (no queueing).
// Ports   : clk, rst (sync, active high); start/image/target/candidateId in;
//           busy/done/score out; clearBest in; bestScore/bestId/bestValid out.
//           Optional macro FITNESS_MASK_EN adds input mask (pixels with mask=0 never count).
module fitness_evaluator
    import fitness_pkg::*;
#(
    parameter int ImageWidth  = 16,
    parameter int ImageHeight = 16,
    parameter int ChunkWidth  = 16,
    parameter int ScoreWidth  = 9,
    parameter int IdWidth     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ImageWidth*ImageHeight-1:0] image,
    input  logic [ImageWidth*ImageHeight-1:0] target,
`ifdef FITNESS_MASK_EN
    input  logic [ImageWidth*ImageHeight-1:0] mask,
`endif
    input  logic [IdWidth-1:0]            candidateId,
    input  logic                          clearBest,
    output logic                          busy,
    output logic                          done,
    output logic [ScoreWidth-1:0]         score,
    output logic [ScoreWidth-1:0]         bestScore,
    output logic [IdWidth-1:0]            bestId,
    output logic                          bestValid
);

    localparam int PixW      = ImageWidth * ImageHeight;
    localparam int NumChunks = num_chunks(ImageWidth, ImageHeight, ChunkWidth);
    localparam int CntW      = cnt_width(NumChunks);
    localparam logic [CntW-1:0]       LastChunk = CntW'(NumChunks - 1);
    localparam logic [ScoreWidth-1:0] ScoreOnes = '1;

    state_e                state_q, state_d;
    logic [PixW-1:0]       diff_q, diff_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [ScoreWidth-1:0] acc_q, acc_d;
    logic [CntW-1:0]       chunk_q, chunk_d;
    logic                  done_q, done_d;
    logic [ScoreWidth-1:0] score_q, score_d;
    logic [ScoreWidth-1:0] best_score_q, best_score_d;
    logic [IdWidth-1:0]    best_id_q, best_id_d;
    logic                  best_valid_q, best_valid_d;

    logic [ScoreWidth-1:0] chunk_ones;
    logic [PixW-1:0]       start_diff;

`ifdef FITNESS_MASK_EN
    assign start_diff = (image ^ target) & mask;
`else
    assign start_diff = image ^ target;
`endif

    // Always counts the low slice; the register shifts so each chunk reaches bit 0 in turn.
    popcount_unit #(
        .ChunkWidth (ChunkWidth),
        .ScoreWidth (ScoreWidth)
    ) u_popcount (
        .vec_i   (diff_q[ChunkWidth-1:0]),
        .count_o (chunk_ones)
    );

    always_comb begin
        state_d      = state_q;
        diff_d       = diff_q;
        id_d         = id_q;
        acc_d        = acc_q;
        chunk_d      = chunk_q;
        done_d       = 1'b0;
        score_d      = score_q;
        best_score_d = best_score_q;
        best_id_d    = best_id_q;
        best_valid_d = best_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    diff_d  = start_diff;
                    id_d    = candidateId;
                    acc_d   = '0;
                    chunk_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_q + chunk_ones;
                diff_d  = diff_q >> ChunkWidth;
                chunk_d = chunk_q + CntW'(1);
                if (chunk_q == LastChunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                score_d = acc_q;
                // Strict less-than: on a tie the earlier candidate stays best.
                if (!best_valid_q || (acc_q < best_score_q)) begin
                    best_score_d = acc_q;
                    best_id_d    = id_q;
                    best_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A clear landing on the completing cycle still keeps that result as the new best.
        if (clearBest) begin
            if (state_q == DONE) begin
                best_score_d = acc_q;
                best_id_d    = id_q;
                best_valid_d = 1'b1;
            end else begin
                best_score_d = ScoreOnes;
                best_id_d    = '0;
                best_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            diff_q       <= '0;
            id_q         <= '0;
            acc_q        <= '0;
            chunk_q      <= '0;
            done_q       <= 1'b0;
            score_q      <= '0;
            best_score_q <= ScoreOnes;
            best_id_q    <= '0;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            diff_q       <= diff_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            chunk_q      <= chunk_d;
            done_q       <= done_d;
            score_q      <= score_d;
            best_score_q <= best_score_d;
            best_id_q    <= best_id_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign score     = score_q;
    assign bestScore = best_score_q;
    assign bestId    = best_id_q;
    assign bestValid = best_valid_q;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Purpose : self-checking bench for fitness_evaluator with a behavioural score/best model.
// Latency : expects done 17 edges after the accepting edge (default parameters).
// Backpressure: exercises ignored start while busy and synchronous abort by rst.
module tb_fitness_evaluator;

    localparam int PixW = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PixW-1:0] image;
    logic [PixW-1:0] target;
    logic [PixW-1:0] mask;
    logic [7:0]      candidateId;
    logic            clearBest;
    logic            busy;
    logic            done;
    logic [8:0]      score;
    logic [8:0]      bestScore;
    logic [7:0]      bestId;
    logic            bestValid;

    int tests = 0;
    int fails = 0;

    // Reference model of the best-tracking registers.
    int         m_best;
    logic [7:0] m_id;
    logic       m_valid;

    always #5 clk = ~clk;

    fitness_evaluator dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .image       (image),
        .target      (target),
`ifdef FITNESS_MASK_EN
        .mask        (mask),
`endif
        .candidateId (candidateId),
        .clearBest   (clearBest),
        .busy        (busy),
        .done        (done),
        .score       (score),
        .bestScore   (bestScore),
        .bestId      (bestId),
        .bestValid   (bestValid)
    );

    function automatic logic [PixW-1:0] rand_vec();
        logic [PixW-1:0] v;
        for (int i = 0; i < PixW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Vector with exactly n distinct set bits at random positions.
    function automatic logic [PixW-1:0] n_bits(input int n);
        logic [PixW-1:0] v;
        v = '0;
        while ($countones(v) < n) v[$urandom_range(PixW-1, 0)] = 1'b1;
        return v;
    endfunction

    function automatic int exp_score(input logic [PixW-1:0] img, input logic [PixW-1:0] tgt,
                                     input logic [PixW-1:0] msk);
`ifdef FITNESS_MASK_EN
        return $countones((img ^ tgt) & msk);
`else
        if (msk == '0) return -1; // mask is ignored in this build
        return $countones(img ^ tgt);
`endif
    endfunction

    function automatic void model_clear();
        m_best  = 511;
        m_id    = 8'd0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_complete(input int s, input logic [7:0] id);
        if (!m_valid || s < m_best) begin
            m_best  = s;
            m_id    = id;
            m_valid = 1'b1;
        end
    endfunction

    // Drives one evaluation and returns the measured latency and score; leaves the
    // bench one cycle after the done pulse.
    task automatic do_eval(input logic [PixW-1:0] img, input logic [PixW-1:0] tgt,
                           input logic [PixW-1:0] msk, input logic [7:0] id,
                           output int lat, output logic [8:0] sc);
        image = img; target = tgt; mask = msk; candidateId = id; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        image = rand_vec(); target = rand_vec(); mask = rand_vec(); candidateId = 8'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        sc = score;
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clearBest = 1'b1;
        @(posedge clk); #1;
        clearBest = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clearBest = 1'b0;
        image = rand_vec(); target = rand_vec(); mask = '1; candidateId = 8'd0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        model_clear();
        tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %0b want 0", done); end
        tests++; if (score !== 9'd0)     begin fails++; $display("FAIL reset_score got %0d want 0", score); end
        tests++; if (bestScore !== 9'd511) begin fails++; $display("FAIL reset_bestScore got %0d want 511", bestScore); end
        tests++; if (bestId !== 8'd0)    begin fails++; $display("FAIL reset_bestId got %0d want 0", bestId); end
        tests++; if (bestValid !== 1'b0) begin fails++; $display("FAIL reset_bestValid got %0b want 0", bestValid); end
    endtask

    task automatic test_equal();
        logic [PixW-1:0] img;
        int lat; logic [8:0] sc;
        img = rand_vec();
        do_eval(img, img, '1, 8'd1, lat, sc);
        model_complete(0, 8'd1);
        tests++; if (lat != 17)        begin fails++; $display("FAIL equal_latency got %0d want 17", lat); end
        tests++; if (sc !== 9'd0)      begin fails++; $display("FAIL equal_score got %0d want 0", sc); end
        tests++; if (bestScore !== 9'd0) begin fails++; $display("FAIL equal_bestScore got %0d want 0", bestScore); end
        tests++; if (bestValid !== 1'b1) begin fails++; $display("FAIL equal_bestValid got %0b want 1", bestValid); end
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL equal_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_inverse();
        logic [PixW-1:0] img;
        int lat; logic [8:0] sc;
        img = rand_vec();
        do_eval(img, ~img, '1, 8'd2, lat, sc);
        model_complete(256, 8'd2);
        tests++; if (sc !== 9'd256) begin fails++; $display("FAIL inverse_score got %0d want 256", sc); end
        tests++; if (bestScore !== 9'(m_best)) begin fails++; $display("FAIL inverse_best got %0d want %0d", bestScore, m_best); end
    endtask

    task automatic test_single_bit();
        logic [PixW-1:0] img, tgt;
        int lat; logic [8:0] sc;
        img = rand_vec(); tgt = img; tgt[255] = ~tgt[255];
        do_eval(img, tgt, '1, 8'd4, lat, sc);
        model_complete(1, 8'd4);
        tests++; if (sc !== 9'd1) begin fails++; $display("FAIL bit255_score got %0d want 1", sc); end
        img = rand_vec(); tgt = img; tgt[0] = ~tgt[0];
        do_eval(img, tgt, '1, 8'd5, lat, sc);
        model_complete(1, 8'd5);
        tests++; if (sc !== 9'd1) begin fails++; $display("FAIL bit0_score got %0d want 1", sc); end
        tests++; if (bestId !== m_id) begin fails++; $display("FAIL tie_bestId got %0d want %0d", bestId, m_id); end
    endtask

    task automatic test_best_tracking();
        int ids[3]  = '{3, 7, 9};
        int diffs[3] = '{10, 5, 5};
        logic [PixW-1:0] img;
        int lat; logic [8:0] sc;
        pulse_clear();
        for (int i = 0; i < 3; i++) begin
            img = rand_vec();
            do_eval(img, img ^ n_bits(diffs[i]), '1, 8'(ids[i]), lat, sc);
            model_complete(diffs[i], 8'(ids[i]));
            tests++; if (sc !== 9'(diffs[i])) begin fails++; $display("FAIL best_seq_score[%0d] got %0d want %0d", i, sc, diffs[i]); end
        end
        tests++; if (bestScore !== 9'(m_best)) begin fails++; $display("FAIL best_seq_bestScore got %0d want %0d", bestScore, m_best); end
        tests++; if (bestId !== m_id)   begin fails++; $display("FAIL best_seq_bestId got %0d want %0d", bestId, m_id); end
        pulse_clear();
        tests++; if (bestScore !== 9'd511) begin fails++; $display("FAIL clear_bestScore got %0d want 511", bestScore); end
        tests++; if (bestValid !== 1'b0)   begin fails++; $display("FAIL clear_bestValid got %0b want 0", bestValid); end
        tests++; if (bestId !== 8'd0)      begin fails++; $display("FAIL clear_bestId got %0d want 0", bestId); end
    endtask

    task automatic test_clear_on_done();
        logic [PixW-1:0] img;
        int lat; logic [8:0] sc;
        img = rand_vec();
        do_eval(img, img, '1, 8'd20, lat, sc);
        model_complete(0, 8'd20);
        img = rand_vec();
        image = img; target = img ^ n_bits(40); candidateId = 8'd21; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1; clearBest = 1'b1;
        @(posedge clk); #1;
        clearBest = 1'b0;
        model_clear();
        model_complete(40, 8'd21);
        tests++; if (done !== 1'b1)   begin fails++; $display("FAIL clrdone_done got %0b want 1", done); end
        tests++; if (bestScore !== 9'(m_best)) begin fails++; $display("FAIL clrdone_bestScore got %0d want %0d", bestScore, m_best); end
        tests++; if (bestId !== m_id) begin fails++; $display("FAIL clrdone_bestId got %0d want %0d", bestId, m_id); end
        tests++; if (bestValid !== 1'b1) begin fails++; $display("FAIL clrdone_bestValid got %0b want 1", bestValid); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [PixW-1:0] img, tgt;
        logic [7:0] id;
        int lat, e; logic [8:0] sc;
        for (int i = 0; i < 8; i++) begin
            img = rand_vec();
            tgt = img ^ (rand_vec() & rand_vec() & rand_vec());
            id  = 8'($urandom);
            e   = exp_score(img, tgt, '1);
            do_eval(img, tgt, '1, id, lat, sc);
            model_complete(e, id);
            tests++; if (sc !== 9'(e) || lat != 17) begin fails++; $display("FAIL random_score[%0d] got %0d/lat %0d want %0d/lat 17", i, sc, lat, e); end
            tests++; if (bestScore !== 9'(m_best) || bestId !== m_id) begin fails++; $display("FAIL random_best[%0d] got %0d/%0d want %0d/%0d", i, bestScore, bestId, m_best, m_id); end
        end
    endtask

    task automatic test_back_to_back();
        logic [PixW-1:0] img;
        int lat1, lat2, e1, e2; logic [8:0] sc1, sc2;
        img = rand_vec();
        e1 = 33;
        do_eval(img, img ^ n_bits(e1), '1, 8'd40, lat1, sc1);
        model_complete(e1, 8'd40);
        img = rand_vec();
        e2 = 77;
        do_eval(img, img ^ n_bits(e2), '1, 8'd41, lat2, sc2);
        model_complete(e2, 8'd41);
        tests++; if (sc1 !== 9'(e1)) begin fails++; $display("FAIL b2b_score1 got %0d want %0d", sc1, e1); end
        tests++; if (lat2 != 17 || sc2 !== 9'(e2)) begin fails++; $display("FAIL b2b_second got %0d/lat %0d want %0d/lat 17", sc2, lat2, e2); end
    endtask

    task automatic test_start_ignored();
        logic [PixW-1:0] img;
        int dones;
        logic [8:0] sc;
        img = rand_vec();
        image = img; target = img ^ n_bits(17); mask = '1; candidateId = 8'd50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        image = rand_vec(); target = ~image;
        dones = 0; sc = '0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin dones++; sc = score; end
        end
        model_complete(17, 8'd50);
        tests++; if (dones != 1)   begin fails++; $display("FAIL ignored_start_dones got %0d want 1", dones); end
        tests++; if (sc !== 9'd17) begin fails++; $display("FAIL ignored_start_score got %0d want 17", sc); end
    endtask

    task automatic test_rst_abort();
        logic [PixW-1:0] img;
        int dones;
        img = rand_vec();
        image = img; target = ~img; candidateId = 8'd60; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL abort_busy got %0b want 0", busy); end
        tests++; if (score !== 9'd0) begin fails++; $display("FAIL abort_score got %0d want 0", score); end
        tests++; if (bestScore !== 9'd511 || bestValid !== 1'b0) begin fails++; $display("FAIL abort_best got %0d/%0b want 511/0", bestScore, bestValid); end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", dones); end
    endtask

`ifdef FITNESS_MASK_EN
    task automatic test_mask();
        logic [PixW-1:0] img;
        int lat; logic [8:0] sc;
        img = rand_vec();
        do_eval(img, ~img, n_bits(12), 8'd70, lat, sc);
        tests++; if (sc !== 9'd12 || lat != 17) begin fails++; $display("FAIL mask_score got %0d/lat %0d want 12/lat 17", sc, lat); end
    endtask
`endif

    initial begin
        test_reset();
        test_equal();
        test_inverse();
        test_single_bit();
        test_best_tracking();
        test_clear_on_done();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_rst_abort();
`ifdef FITNESS_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
